imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the instruction fetch path. Receives a program image as a byte stream and writes 16-bit instruction words into the instruction memory's write port.
- Holds the CPU (PC stalled) while loading, so fetch only starts after the image is fully committed.
- Sits between the host byte link (UART/debug bridge) and the instruction RAM.

Parameters:
- ADDR_W, 16, instruction memory address width (word-addressed)
- DEPTH, 1024, number of writable instruction words; length headers above this are rejected
- BASE_ADDR, 0, first word address written

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a load session (ignored unless IDLE, DONE or ERROR)
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- mem_wen  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  16  instruction word
- cpu_hold  out  1  1 = PC must not advance (drives PC stall control)
- busy  out  1  session in progress
- done  out  1  sticky: image loaded successfully
- error  out  1  sticky: length or checksum failure
- words_loaded  out  ADDR_W  count of words written this session

Behaviour:
- Reset (async, reset_n=0): state IDLE; rx_ready=0, mem_wen=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, words_loaded=0. The CPU is held until a successful load has completed.
- Byte handshake: a byte transfers on a clock edge where rx_valid && rx_ready. rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM. rx_data is ignored otherwise.
- States:
  - IDLE/DONE/ERROR + start -> LEN_HI. This clears done, error and words_loaded, sets cpu_hold=1 and busy=1.
  - LEN_HI: accept byte -> len[15:8]; go to LEN_LO.
  - LEN_LO: accept byte -> len[7:0]. If len==0 -> FINISH. If len>DEPTH -> ERROR. Else -> DATA_HI.
  - DATA_HI: accept byte -> hold register; go to DATA_LO.
  - DATA_LO: accept byte. Next cycle: mem_wen=1, mem_wdata={hold,byte}, mem_addr=BASE_ADDR+words_loaded. One-cycle latency from the last byte to the write.
    - words_loaded increments in the same cycle as mem_wen.
    - If the word just written is number len -> FINISH, else -> DATA_HI.
  - FINISH (one cycle): done=1, busy=0, cpu_hold=0 -> DONE.
  - ERROR: error=1, busy=0, cpu_hold stays 1. Partially written memory is left as-is.
- Byte order: big-endian (high byte first).
- Address arithmetic: BASE_ADDR+words_loaded, truncated to ADDR_W. No wrap can occur because len<=DEPTH.
- start asserted while busy: ignored.
- rx_valid held low mid-session: the loader waits indefinitely. There is no timeout.
- reset_n low mid-session: immediate return to reset values. Any partial image is discarded logically (cpu_hold=1).
- Writes never coincide with rx_ready=1 in the write cycle. rx_ready=0 in the cycle mem_wen=1, so one byte bubble per word.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, the loader moves to CSUM instead of FINISH. len==0 also goes to CSUM.
  - CSUM accepts one byte, compared against the running XOR of all data bytes (not the length bytes).
  - Match -> FINISH. Mismatch -> ERROR.
- Undefined: no CSUM state; the last word goes directly to FINISH.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum typedef (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, FINISH, DONE, ERROR)
  - constant BYTE_W=8
  - constant INSTR_W=16
- No sub-module required. The byte-to-word assembler is small enough to stay inline.

Test Plan:
- Reset, then start; stream 00 03 12 34 AB CD 00 01 -> three writes: addr0=1234, addr1=ABCD, addr2=0001. Then done=1, cpu_hold=0, words_loaded=3.
- Length 00 00 -> done=1 one cycle after LEN_LO, no mem_wen. With checksum enabled, a CSUM byte 00 is required.
- Length exceeding DEPTH (DEPTH=1024, header 04 01) -> error=1, cpu_hold=1, no writes, rx_ready=0.
- rx_valid toggled randomly with gaps of 0-5 cycles during a 4-word image -> identical write contents, exactly one mem_wen per word.
- reset_n pulsed low after 2 words of a 4-word load -> all outputs at reset values. A new start with a fresh image loads correctly from BASE_ADDR.
- IMEM_LOADER_CHECKSUM_EN: image 00 01 12 34 with CSUM 26 -> done=1. The same image with CSUM 27 -> error=1 after the word was written.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and widths for the instruction memory loader.
package imem_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CSUM,
        FINISH,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed big-endian byte image into instruction memory, holding the CPU until done.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over the data bytes.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               mem_wen,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ADDR_W-1:0]  words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = FINISH;
`endif

    state_t            state, state_nxt;
    logic [15:0]       len, len_full;
    logic [BYTE_W-1:0] hold, csum;
    logic              fire, last_word, can_start;

    assign rx_ready  = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
    assign fire      = rx_valid && rx_ready;
    assign len_full  = {len[15:8], rx_data};
    assign last_word = 32'(words_loaded) == 32'(len);
    assign can_start = state inside {IDLE, DONE, ERROR};
    assign done      = state inside {FINISH, DONE};
    assign error     = state == ERROR;
    assign cpu_hold  = !done;
    assign busy      = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: state_nxt = start ? LEN_HI : state;
            LEN_HI:  state_nxt = fire ? LEN_LO : state;
            LEN_LO:  state_nxt = !fire ? state : len_full == 16'd0 ? AFTER_DATA :
                                 32'(len_full) > DEPTH ? ERROR : DATA_HI;
            DATA_HI: state_nxt = fire ? DATA_LO : state;
            DATA_LO: state_nxt = fire ? WRITE : state;
            WRITE:   state_nxt = last_word ? AFTER_DATA : DATA_HI;
            CSUM:    state_nxt = !fire ? state : rx_data == csum ? FINISH : ERROR;
            FINISH:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // The word is registered on the low byte so the write lands one cycle later with rx_ready low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len          <= '0;
            hold         <= '0;
            csum         <= '0;
            mem_wen      <= 1'b0;
            mem_addr     <= ADDR_W'(BASE_ADDR);
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_wen <= 1'b0;
            if (can_start && start) begin
                words_loaded <= '0;
                csum         <= '0;
            end
            if (fire) begin
                case (state)
                    LEN_HI:  len[15:8] <= rx_data;
                    LEN_LO:  len[7:0]  <= rx_data;
                    DATA_HI: begin
                        hold <= rx_data;
                        csum <= csum ^ rx_data;
                    end
                    DATA_LO: begin
                        mem_wen      <= 1'b1;
                        mem_wdata    <= {hold, rx_data};
                        mem_addr     <= ADDR_W'(BASE_ADDR) + words_loaded;
                        words_loaded <= words_loaded + 1'b1;
                        csum         <= csum ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the image loader, with and without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clock = 0, reset_n = 0, start = 0, rx_valid = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_ready, mem_wen, cpu_hold, busy, done, error;
    logic [15:0] mem_addr, mem_wdata, words_loaded;

    int vectors = 0, miscompares = 0;
    logic [7:0]  img[$];
    logic [15:0] wa[$], wd[$], ex[$];

    always #5 clock = ~clock;

    imem_loader dut (
        .clock(clock), .reset_n(reset_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always @(negedge clock) if (mem_wen) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        rx_data  = b;
        rx_valid = 1;
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 1);
        @(posedge clock);
        @(negedge clock);
        rx_valid = 0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_img(input int maxgap);
        foreach (img[i]) send_byte(img[i], i == img.size() - 1 ? 0 : $urandom_range(0, maxgap));
    endtask

    task automatic begin_session();
        @(negedge clock);
        start = 1;
        @(negedge clock);
        start = 0;
        wa.delete();
        wd.delete();
    endtask

    task automatic wait_end();
        int n = 0;
        while (!done && !error && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("end_timeout", 32'(done | error), 1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, wa.size(), ex.size());
        foreach (ex[i]) begin
            check({tag, "_addr"}, i < wa.size() ? 32'(wa[i]) : 32'hxxxx, i);
            check({tag, "_data"}, i < wd.size() ? 32'(wd[i]) : 32'hxxxx, 32'(ex[i]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_mem_wen"}, 32'(mem_wen), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1;

        // three-word image
        begin_session();
        check("t1_busy", 32'(busy), 1);
        img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(8'h41);
`endif
        send_img(0);
        wait_end();
        ex = '{16'h1234, 16'hABCD, 16'h0001};
        check_writes("t1");
        check("t1_done", 32'(done), 1);
        check("t1_cpu_hold", 32'(cpu_hold), 0);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_words", 32'(words_loaded), 3);

        // zero-length image
        begin_session();
        check("t2_done_cleared", 32'(done), 0);
        img = '{8'h00, 8'h00};
        send_img(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t2_csum_ready", 32'(rx_ready), 1);
        check("t2_done_early", 32'(done), 0);
        send_byte(8'h00, 0);
`endif
        check("t2_done", 32'(done), 1);
        check("t2_words", 32'(words_loaded), 0);
        check("t2_wen_count", wa.size(), 0);

        // oversize length header
        begin_session();
        img = '{8'h04, 8'h01};
        send_img(0);
        check("t3_error", 32'(error), 1);
        check("t3_cpu_hold", 32'(cpu_hold), 1);
        check("t3_rx_ready", 32'(rx_ready), 0);
        check("t3_busy", 32'(busy), 0);
        check("t3_done", 32'(done), 0);
        repeat (3) @(negedge clock);
        check("t3_wen_count", wa.size(), 0);

        // four words with random rx_valid gaps and a start pulse mid-session
        begin_session();
        img = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_img(5);
        start = 1;
        @(negedge clock);
        start = 0;
        img = '{8'h01, 8'h02, 8'hA5, 8'h5A};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(8'hDE);
`endif
        send_img(5);
        wait_end();
        ex = '{16'hDEAD, 16'hBEEF, 16'h0102, 16'hA55A};
        check_writes("t4");
        check("t4_done", 32'(done), 1);
        check("t4_words", 32'(words_loaded), 4);

        // reset mid-load, then a fresh image
        begin_session();
        img = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_img(0);
        @(negedge clock);
        check("t5_partial_writes", wa.size(), 2);
        check("t5_partial_words", 32'(words_loaded), 2);
        reset_n = 0;
        #1;
        check_reset_values("t5_reset");
        @(negedge clock);
        reset_n = 1;
        begin_session();
        img = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'h13, 8'h57};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(8'h70);
`endif
        send_img(2);
        wait_end();
        ex = '{16'hCAFE, 16'h1357};
        check_writes("t5");
        check("t5_done", 32'(done), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        begin_session();
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        send_img(0);
        wait_end();
        check("t6_good_done", 32'(done), 1);
        check("t6_good_error", 32'(error), 0);
        begin_session();
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        send_img(0);
        wait_end();
        ex = '{16'h1234};
        check_writes("t6_bad");
        check("t6_bad_error", 32'(error), 1);
        check("t6_bad_done", 32'(done), 0);
        check("t6_bad_cpu_hold", 32'(cpu_hold), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
